regfile_debug_arbiter: RTL

- Shares the general-purpose register file between the microcode datapath (core) and the debug port.
- The core owns the file by default. Debug reads and writes of any 16-bit GPR are inserted at instruction boundaries (core_idle).
- If the core does not reach a boundary within STARVE_LIMIT cycles, the block forces a stall so the debug access can complete.
- Sits between the microcode sequencer, the debug unit and the register file's read port 0 and write port.

---
 rtl/regfile_debug_arbiter_pkg.sv | 48 ++++
 rtl/regfile_starve_counter.sv | 36 +++
 rtl/regfile_debug_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/regfile_debug_arbiter_pkg.sv
// Shared definitions for the register-file debug arbiter.
//   gpr_t               : 3-bit GPR index (AX..DI), with the 8-bit register aliases
//                         that the register file decodes when is_8_bit is set.
//   regfile_dbg_state_t : debug access FSM states.
//   cnt_width()         : width of the starvation counter for a given limit.
//   dbg_owns_rf()       : true in states where the debug path drives the file.
package regfile_debug_arbiter_pkg;

    typedef enum logic [2:0] {
        GPR_AX = 3'd0,
        GPR_CX = 3'd1,
        GPR_DX = 3'd2,
        GPR_BX = 3'd3,
        GPR_SP = 3'd4,
        GPR_BP = 3'd5,
        GPR_SI = 3'd6,
        GPR_DI = 3'd7
    } gpr_t;

    // Byte-register aliases share the 16-bit encodings (low bytes 0-3, high bytes 4-7).
    localparam gpr_t GPR_AL = GPR_AX;
    localparam gpr_t GPR_CL = GPR_CX;
    localparam gpr_t GPR_DL = GPR_DX;
    localparam gpr_t GPR_BL = GPR_BX;
    localparam gpr_t GPR_AH = GPR_SP;
    localparam gpr_t GPR_CH = GPR_BP;
    localparam gpr_t GPR_DH = GPR_SI;
    localparam gpr_t GPR_BH = GPR_DI;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_IDLE  = 3'd1,
        RD_ISSUE   = 3'd2,
        RD_CAPTURE = 3'd3,
        WR_ISSUE   = 3'd4,
        ACK        = 3'd5
    } regfile_dbg_state_t;

    // A limit of 0 still needs a 1-bit counter so the compare is well formed.
    function automatic int cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

    function automatic logic dbg_owns_rf(input regfile_dbg_state_t s);
        return !((s == IDLE) || (s == WAIT_IDLE));
    endfunction

endpackage

// File: rtl/regfile_starve_counter.sv
// Saturating wait counter for a pending debug request.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   i_clr      : return the count to 0 (has priority over i_inc)
//   i_inc      : advance the count by one, saturating at STARVE_LIMIT
//   o_hit      : count == STARVE_LIMIT
module regfile_starve_counter
    import regfile_debug_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = cnt_width(STARVE_LIMIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit = (r_cnt == CNT_W'(STARVE_LIMIT));
    assign o_hit = w_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_hit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Shares register-file read port 0 and the write port between the microcode
// core and the debug unit. The core owns the file by default; a debug access
// is granted when the core reports an instruction boundary (core_idle), or the
// core is stalled after STARVE_LIMIT cycles of waiting and the access then
// proceeds at the next boundary.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   core_idle                       : core at boundary, not using the file
//   core_rd_sel0/core_wr_*          : core register-file requests
//   core_is_8_bit                   : core byte-mode flag
//   core_stall                      : core must hold (debug owns the file)
//   rf_rd_sel0, rf_rd_val0          : register file read port 0 (1-cycle read)
//   rf_wr_sel/val/en, rf_is_8_bit   : register file write port and byte mode
//   dbg_req/wr/sel/wr_val           : debug request, held until dbg_ack
//   dbg_ack, dbg_rd_val             : completion pulse and read data
//   protocol_err                    : sticky, core wrote while debug owned the file
module regfile_debug_arbiter
    import regfile_debug_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_idle,
    input  logic [2:0]  core_rd_sel0,
    input  logic [2:0]  core_wr_sel,
    input  logic [15:0] core_wr_val,
    input  logic        core_wr_en,
    input  logic        core_is_8_bit,
    output logic        core_stall,
    output logic [2:0]  rf_rd_sel0,
    input  logic [15:0] rf_rd_val0,
    output logic [2:0]  rf_wr_sel,
    output logic [15:0] rf_wr_val,
    output logic        rf_wr_en,
    output logic        rf_is_8_bit,
    input  logic        dbg_req,
    input  logic        dbg_wr,
    input  logic [2:0]  dbg_sel,
    input  logic [15:0] dbg_wr_val,
    output logic        dbg_ack,
    output logic [15:0] dbg_rd_val,
    output logic        protocol_err
);

    localparam int CNT_W = cnt_width(STARVE_LIMIT);

    regfile_dbg_state_t r_state;
    regfile_dbg_state_t w_next;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_hit;
    logic               w_owns;
    logic               r_core_stall;
    logic               r_dbg_ack;
    logic [15:0]        r_dbg_rd_val;
    logic               r_protocol_err;

    regfile_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_hit (w_hit)
    );

    assign w_owns = dbg_owns_rf(r_state);

    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            IDLE: begin
                if (!dbg_req) begin
                    w_cnt_clr = 1'b1;
                end else if (core_idle) begin
                    w_cnt_clr = 1'b1;
                    w_next    = dbg_wr ? WR_ISSUE : RD_ISSUE;
                end else if (w_hit) begin
                    w_next = WAIT_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (core_idle) begin
                    w_cnt_clr = 1'b1;
                    w_next    = dbg_wr ? WR_ISSUE : RD_ISSUE;
                end
            end
            RD_ISSUE:   w_next = RD_CAPTURE;
            RD_CAPTURE: w_next = ACK;
            WR_ISSUE:   w_next = ACK;
            ACK:        w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // Register-file port mux: core passes straight through unless debug owns the file.
    always_comb begin
        rf_rd_sel0  = core_rd_sel0;
        rf_wr_sel   = core_wr_sel;
        rf_wr_val   = core_wr_val;
        rf_wr_en    = core_wr_en;
        rf_is_8_bit = core_is_8_bit;
        if (w_owns) begin
            rf_rd_sel0  = dbg_sel;
            rf_wr_sel   = dbg_sel;
            rf_wr_val   = dbg_wr_val;
            rf_wr_en    = (r_state == WR_ISSUE);
            rf_is_8_bit = 1'b0;
        end
    end

    // Stall and ack are flopped from the next state, so they track r_state
    // exactly but come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_core_stall   <= 1'b0;
            r_dbg_ack      <= 1'b0;
            r_dbg_rd_val   <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_core_stall <= (w_next != IDLE);
            r_dbg_ack    <= (w_next == ACK);
            if (r_state == RD_CAPTURE) begin
                r_dbg_rd_val <= rf_rd_val0;
            end
            if (w_owns && core_wr_en) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign core_stall   = r_core_stall;
    assign dbg_ack      = r_dbg_ack;
    assign dbg_rd_val   = r_dbg_rd_val;
    assign protocol_err = r_protocol_err;

endmodule
